// File: rtl/cla_self_test_engine_if.sv
// Handshake and adder-facing signal bundle for the CLA self-test engine.
// The master modport is the engine; the slave modport is the host plus adder side.
interface cla_self_test_engine_if #(
   parameter int unsigned CNT_W = 16,
   parameter int unsigned ERR_W = 16
);

   // Run control from the host
   logic             start;
   logic [CNT_W-1:0] num_vectors;

   // Operands to the adder and its response
   logic [31:0]      dut_a;
   logic [31:0]      dut_b;
   logic             dut_cin;
   logic [31:0]      dut_s;
   logic             dut_cout;

   // Run status and results
   logic             busy;
   logic             done;
   logic             pass;
   logic [ERR_W-1:0] err_count;
   logic [CNT_W-1:0] first_fail_idx;

   modport master (
      input  start, num_vectors, dut_s, dut_cout,
      output dut_a, dut_b, dut_cin, busy, done, pass, err_count, first_fail_idx
   );

   modport slave (
      output start, num_vectors, dut_s, dut_cout,
      input  dut_a, dut_b, dut_cin, busy, done, pass, err_count, first_fail_idx
   );

endinterface

// File: rtl/cla_self_test_engine.sv
// Built-in self-test driver/checker for a 32-bit CLA adder. Operands come from a
// Galois LFSR, are held for a settle window, and the adder response is compared
// against a sum computed here when the operands were loaded.
module cla_self_test_engine #(
   parameter logic [31:0] SEED          = 32'h0000_0001, // must be nonzero
   parameter logic [31:0] POLY          = 32'h8020_0003,
   parameter int unsigned SETTLE_CYCLES = 2,             // must be >= 1
   parameter int unsigned CNT_W         = 16,
   parameter int unsigned ERR_W         = 16
) (
   input logic                    clk,
   input logic                    rst,
   cla_self_test_engine_if.master bus
);

   localparam int unsigned SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

   typedef enum logic [1:0] {
      StIdle,
      StSettle,
      StCheck,
      StDone
   } state_e;

   // One Galois LFSR shift
   function automatic logic [31:0] lfsr_step(input logic [31:0] s);
      return (s >> 1) ^ (s[0] ? POLY : 32'h0);
   endfunction

   state_e           state_q, state_d;
   logic [31:0]      lfsr_q, lfsr_d;
   logic [31:0]      a_q, a_d;
   logic [31:0]      b_q, b_d;
   logic             cin_q, cin_d;
   logic [31:0]      exp_s_q, exp_s_d;
   logic             exp_cout_q, exp_cout_d;
   logic [CNT_W-1:0] nvec_q, nvec_d;
   logic [CNT_W-1:0] idx_q, idx_d;
   logic [SW-1:0]    settle_q, settle_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             pass_q, pass_d;
   logic [ERR_W-1:0] err_q, err_d;
   logic [CNT_W-1:0] ffi_q, ffi_d;

   // Vector generation scratch
   logic             load;
   logic             load_from_seed;
   logic [31:0]      vec_l;
   logic [31:0]      vec_m;
   logic [32:0]      vec_sum;
   logic             vec_cin;

   // Checking scratch
   logic             mismatch;
   logic [ERR_W-1:0] err_next;

   // Build the next vector from either SEED (run start) or the running LFSR
   always_comb begin
      vec_l   = load_from_seed ? SEED : lfsr_q;
      vec_m   = lfsr_step(vec_l);
      vec_cin = vec_l[0] ^ vec_m[31];
      vec_sum = {1'b0, vec_l} + {1'b0, vec_m} + {32'h0, vec_cin};
   end

   // Response compare and saturating error increment
   always_comb begin
      mismatch = ({bus.dut_cout, bus.dut_s} != {exp_cout_q, exp_s_q});
      err_next = err_q;
      if (mismatch && (err_q != '1)) begin
         err_next = err_q + ERR_W'(1);
      end
   end

   // Next-state and datapath control
   always_comb begin
      state_d        = state_q;
      lfsr_d         = lfsr_q;
      a_d            = a_q;
      b_d            = b_q;
      cin_d          = cin_q;
      exp_s_d        = exp_s_q;
      exp_cout_d     = exp_cout_q;
      nvec_d         = nvec_q;
      idx_d          = idx_q;
      settle_d       = settle_q;
      busy_d         = busy_q;
      done_d         = done_q;
      pass_d         = pass_q;
      err_d          = err_q;
      ffi_d          = ffi_q;
      load           = 1'b0;
      load_from_seed = 1'b0;

      unique case (state_q)
         StIdle, StDone: begin
            if (bus.start) begin
               nvec_d = bus.num_vectors;
               err_d  = '0;
               ffi_d  = '1;
               pass_d = 1'b0;
               done_d = 1'b0;
               idx_d  = '0;
               if (bus.num_vectors == '0) begin
                  // Empty run finishes immediately and trivially passes
                  state_d = StDone;
                  done_d  = 1'b1;
                  pass_d  = 1'b1;
               end else begin
                  load           = 1'b1;
                  load_from_seed = 1'b1;
                  busy_d         = 1'b1;
                  settle_d       = '0;
                  state_d        = StSettle;
               end
            end
         end

         StSettle: begin
            if (settle_q == SETTLE_LAST) begin
               state_d = StCheck;
            end else begin
               settle_d = settle_q + SW'(1);
            end
         end

         StCheck: begin
            err_d = err_next;
            if (mismatch && (ffi_q == '1)) begin
               ffi_d = idx_q;
            end
            if (idx_q == nvec_q - CNT_W'(1)) begin
               state_d = StDone;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               pass_d  = (err_next == '0);
            end else begin
               idx_d    = idx_q + CNT_W'(1);
               load     = 1'b1;
               settle_d = '0;
               state_d  = StSettle;
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase

      if (load) begin
         a_d        = vec_l;
         b_d        = vec_m;
         cin_d      = vec_cin;
         exp_s_d    = vec_sum[31:0];
         exp_cout_d = vec_sum[32];
         lfsr_d     = lfsr_step(vec_m);
      end
   end

   // State and datapath registers; reset aborts any run in progress
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         lfsr_q     <= SEED;
         a_q        <= '0;
         b_q        <= '0;
         cin_q      <= 1'b0;
         exp_s_q    <= '0;
         exp_cout_q <= 1'b0;
         nvec_q     <= '0;
         idx_q      <= '0;
         settle_q   <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         pass_q     <= 1'b0;
         err_q      <= '0;
         ffi_q      <= '1;
      end else begin
         state_q    <= state_d;
         lfsr_q     <= lfsr_d;
         a_q        <= a_d;
         b_q        <= b_d;
         cin_q      <= cin_d;
         exp_s_q    <= exp_s_d;
         exp_cout_q <= exp_cout_d;
         nvec_q     <= nvec_d;
         idx_q      <= idx_d;
         settle_q   <= settle_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         pass_q     <= pass_d;
         err_q      <= err_d;
         ffi_q      <= ffi_d;
      end
   end

   assign bus.dut_a          = a_q;
   assign bus.dut_b          = b_q;
   assign bus.dut_cin        = cin_q;
   assign bus.busy           = busy_q;
   assign bus.done           = done_q;
   assign bus.pass           = pass_q;
   assign bus.err_count      = err_q;
   assign bus.first_fail_idx = ffi_q;

endmodule

// File: tb/tb_cla_self_test_engine.sv
// Self-checking bench for cla_self_test_engine with a fault-injectable adder model.
module tb_cla_self_test_engine;

   localparam logic [31:0] SEED = 32'h0000_0001;
   localparam logic [31:0] POLY = 32'h8020_0003;
   localparam int          HOLD = 3; // SETTLE_CYCLES + 1

   logic clk;
   logic rst;

   int tests_run = 0;
   int tests_failed = 0;

   // 0 ideal, 1 s[0] inverted, 2 s[0] inverted when cin=1, 3 s ^= mask when (a^b)[2:0]==0
   int          fault_mode = 0;
   logic [31:0] fault_mask = 32'h1;
   logic [32:0] add_res;

   cla_self_test_engine_if #(.CNT_W(16), .ERR_W(16)) bus ();

   cla_self_test_engine #(
      .SEED(SEED),
      .POLY(POLY),
      .SETTLE_CYCLES(2),
      .CNT_W(16),
      .ERR_W(16)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Adder under test, with optional planted faults
   always_comb begin
      add_res = {1'b0, bus.dut_a} + {1'b0, bus.dut_b} + {32'h0, bus.dut_cin};
      if (fault_mode == 1) add_res[0] = ~add_res[0];
      if (fault_mode == 2 && bus.dut_cin) add_res[0] = ~add_res[0];
      if (fault_mode == 3 && (((bus.dut_a ^ bus.dut_b) % 8) == 0))
         add_res[31:0] = add_res[31:0] ^ fault_mask;
   end
   assign bus.dut_s    = add_res[31:0];
   assign bus.dut_cout = add_res[32];

   // Reference: Galois shift expressed arithmetically
   function automatic logic [31:0] ref_step(input logic [31:0] s);
      return (s / 2) ^ (((s % 2) == 1) ? POLY : 32'h0);
   endfunction

   // Reference: vector k of a run started from SEED
   task automatic ref_vec(input int k, output logic [31:0] a, output logic [31:0] b,
                          output logic c);
      logic [31:0] l;
      l = SEED;
      for (int i = 0; i < k; i++) l = ref_step(ref_step(l));
      a = l;
      b = ref_step(l);
      c = l[0] ^ b[31];
   endtask

   // Reference: does the planted fault make vector (a,b,c) disagree with an ideal sum
   function automatic bit ref_bad(input int mode, input logic [31:0] a, input logic [31:0] b,
                                  input logic c, input logic [31:0] mask);
      case (mode)
         1: return 1'b1;
         2: return c;
         3: return (((a ^ b) % 8) == 0) && (mask != 0);
         default: return 1'b0;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Run n vectors; optionally pulse start with another length during vector poke
   task automatic run_vectors(input int n, input int poke, input string name);
      logic [31:0] ea, eb;
      logic        ec;
      int          exp_err;
      int          exp_ffi;
      exp_err = 0;
      exp_ffi = 16'hFFFF;
      for (int k = 0; k < n; k++) begin
         ref_vec(k, ea, eb, ec);
         if (ref_bad(fault_mode, ea, eb, ec, fault_mask)) begin
            if (exp_ffi == 16'hFFFF) exp_ffi = k;
            exp_err++;
         end
      end

      bus.start = 1'b1;
      bus.num_vectors = 16'(n);
      tick();
      bus.start = 1'b0;
      bus.num_vectors = 16'($urandom_range(0, 40));

      for (int k = 0; k < n; k++) begin
         ref_vec(k, ea, eb, ec);
         tests_run++;
         if (bus.dut_a !== ea || bus.dut_b !== eb || bus.dut_cin !== ec) begin
            tests_failed++;
            $display("FAIL %s vec%0d: got a=%h b=%h cin=%b want a=%h b=%h cin=%b", name, k,
                     bus.dut_a, bus.dut_b, bus.dut_cin, ea, eb, ec);
         end
         tests_run++;
         if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s status vec%0d: got busy=%b done=%b want busy=1 done=0", name, k,
                     bus.busy, bus.done);
         end
         if (k == poke) begin
            bus.start = 1'b1;
            bus.num_vectors = 16'd3;
            tick();
            bus.start = 1'b0;
            repeat (HOLD - 1) tick();
         end else begin
            repeat (HOLD) tick();
         end
      end

      tests_run++;
      if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.pass !== (exp_err == 0)) begin
         tests_failed++;
         $display("FAIL %s end: got done=%b busy=%b pass=%b want done=1 busy=0 pass=%b", name,
                  bus.done, bus.busy, bus.pass, exp_err == 0);
      end
      tests_run++;
      if (bus.err_count !== 16'(exp_err) || bus.first_fail_idx !== 16'(exp_ffi)) begin
         tests_failed++;
         $display("FAIL %s result: got err=%0d ffi=%h want err=%0d ffi=%h", name,
                  bus.err_count, bus.first_fail_idx, exp_err, exp_ffi[15:0]);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.start = 1'b0;
      bus.num_vectors = '0;
      #12;
      tests_run++;
      if (bus.dut_a !== 0 || bus.dut_b !== 0 || bus.dut_cin !== 0 || bus.busy !== 0 ||
          bus.done !== 0 || bus.pass !== 0 || bus.err_count !== 0 ||
          bus.first_fail_idx !== 16'hFFFF) begin
         tests_failed++;
         $display("FAIL reset: got a=%h b=%h cin=%b busy=%b done=%b pass=%b err=%0d ffi=%h",
                  bus.dut_a, bus.dut_b, bus.dut_cin, bus.busy, bus.done, bus.pass,
                  bus.err_count, bus.first_fail_idx);
      end
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_known_vector();
      fault_mode = 0;
      bus.start = 1'b1;
      bus.num_vectors = 16'd1;
      tick();
      bus.start = 1'b0;
      tests_run++;
      if (bus.dut_a !== 32'h0000_0001 || bus.dut_b !== 32'h8020_0003 || bus.dut_cin !== 1'b0 ||
          add_res !== 33'h0_8020_0004) begin
         tests_failed++;
         $display("FAIL known_vec: got a=%h b=%h cin=%b sum=%h want 1 80200003 0 080200004",
                  bus.dut_a, bus.dut_b, bus.dut_cin, add_res);
      end
      repeat (2) tick();
      tests_run++;
      if (bus.done !== 1'b0) begin
         tests_failed++;
         $display("FAIL known_early: got done=%b want 0", bus.done);
      end
      tick();
      tests_run++;
      if (bus.done !== 1'b1 || bus.pass !== 1'b1 || bus.busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL known_done: got done=%b pass=%b busy=%b want 1 1 0", bus.done,
                  bus.pass, bus.busy);
      end
   endtask

   task automatic test_ideal_16();
      fault_mode = 0;
      run_vectors(16, -1, "ideal16");
   endtask

   task automatic test_inverted_s0();
      fault_mode = 1;
      run_vectors(10, -1, "inv_s0");
      tests_run++;
      if (bus.err_count !== 16'd10 || bus.first_fail_idx !== 16'd0 || bus.pass !== 1'b0) begin
         tests_failed++;
         $display("FAIL inv_s0_fixed: got err=%0d ffi=%0d pass=%b want 10 0 0", bus.err_count,
                  bus.first_fail_idx, bus.pass);
      end
      fault_mode = 0;
   endtask

   task automatic test_cin_fault();
      fault_mode = 2;
      run_vectors(20, -1, "cin_fault");
      fault_mode = 0;
   endtask

   task automatic test_zero_vectors();
      bus.start = 1'b1;
      bus.num_vectors = 16'd0;
      tick();
      bus.start = 1'b0;
      tests_run++;
      if (bus.done !== 1'b1 || bus.pass !== 1'b1 || bus.busy !== 1'b0 ||
          bus.err_count !== 0 || bus.first_fail_idx !== 16'hFFFF) begin
         tests_failed++;
         $display("FAIL zero_vec: got done=%b pass=%b busy=%b err=%0d ffi=%h want 1 1 0 0 ffff",
                  bus.done, bus.pass, bus.busy, bus.err_count, bus.first_fail_idx);
      end
   endtask

   task automatic test_random();
      for (int r = 0; r < 6; r++) begin
         fault_mode = $urandom_range(0, 3);
         fault_mask = $urandom | 32'h1;
         run_vectors($urandom_range(1, 24), -1, "random");
      end
      fault_mode = 0;
   endtask

   task automatic test_start_while_busy();
      fault_mode = 2;
      run_vectors(8, 2, "start_busy");
      fault_mode = 0;
   endtask

   task automatic test_mid_run_reset();
      bus.start = 1'b1;
      bus.num_vectors = 16'd16;
      tick();
      bus.start = 1'b0;
      repeat (20) tick();
      rst = 1'b1;
      #1;
      tests_run++;
      if (bus.dut_a !== 0 || bus.dut_b !== 0 || bus.dut_cin !== 0 || bus.busy !== 0 ||
          bus.done !== 0 || bus.pass !== 0 || bus.err_count !== 0 ||
          bus.first_fail_idx !== 16'hFFFF) begin
         tests_failed++;
         $display("FAIL mid_reset: got a=%h busy=%b done=%b pass=%b err=%0d ffi=%h",
                  bus.dut_a, bus.busy, bus.done, bus.pass, bus.err_count, bus.first_fail_idx);
      end
      tick();
      rst = 1'b0;
      tick();
      tests_run++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
         tests_failed++;
         $display("FAIL post_reset_idle: got busy=%b done=%b want 0 0", bus.busy, bus.done);
      end
      run_vectors(16, -1, "rerun");
   endtask

   task automatic test_back_to_back();
      logic [31:0] ea, eb;
      logic        ec;
      fault_mode = 0;
      bus.start = 1'b1;
      bus.num_vectors = 16'd2;
      tick();
      repeat (2 * HOLD) tick();
      tests_run++;
      if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL b2b_first_done: got done=%b busy=%b want 1 0", bus.done, bus.busy);
      end
      tick();
      bus.start = 1'b0;
      ref_vec(0, ea, eb, ec);
      tests_run++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b1 || bus.dut_a !== ea || bus.dut_b !== eb) begin
         tests_failed++;
         $display("FAIL b2b_restart: got done=%b busy=%b a=%h b=%h want 0 1 %h %h", bus.done,
                  bus.busy, bus.dut_a, bus.dut_b, ea, eb);
      end
      repeat (HOLD) tick();
      ref_vec(1, ea, eb, ec);
      tests_run++;
      if (bus.dut_a !== ea || bus.dut_b !== eb || bus.dut_cin !== ec) begin
         tests_failed++;
         $display("FAIL b2b_vec1: got a=%h b=%h cin=%b want %h %h %b", bus.dut_a, bus.dut_b,
                  bus.dut_cin, ea, eb, ec);
      end
      repeat (HOLD) tick();
      tests_run++;
      if (bus.done !== 1'b1 || bus.pass !== 1'b1 || bus.dut_a !== ea) begin
         tests_failed++;
         $display("FAIL b2b_second_done: got done=%b pass=%b a=%h want 1 1 %h", bus.done,
                  bus.pass, bus.dut_a, ea);
      end
   endtask

   initial begin
      test_reset();
      test_known_vector();
      test_ideal_16();
      test_inverted_s0();
      test_cin_fault();
      test_zero_vectors();
      test_random();
      test_start_while_busy();
      test_mid_run_reset();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
